// File: rtl/dbus_req_ctrl_if.sv
// Data bus types and the interface that carries them.
//   dbus_pkg        : access size encoding, request and response structs.
//   dbus_req_ctrl_if: dreq (request, master -> slave) and
//                     dresp (response, slave -> master).
//   master modport  : drives dreq, samples dresp (used by dbus_req_ctrl).
//   slave modport   : samples dreq, drives dresp (memory side / bench).
package dbus_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

interface dbus_req_ctrl_if;
  import dbus_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_req_ctrl.sv
// Memory-stage data bus request controller.
// Turns a load/store from the memory stage into one data bus transaction,
// holds the request stable until data_ok, then reports completion with a
// one-cycle resp_valid pulse and the extended load result.
// Ports:
//   clk, reset_n            : clock and asynchronous active-low reset
//   op_valid, memRead,
//   memWrite, funct3,
//   memAddr, writeData      : operation presented by the memory stage
//   flush                   : discard the current operation's result
//   stall                   : hold the memory stage
//   resp_valid, readData    : completion pulse and load result
//   misalign                : misaligned / illegal access, not issued
//   dbus (master)           : dreq out, dresp in
//
// state | meaning
// IDLE  | waiting for an operation; starts or rejects it
// REQ   | dreq.valid high, request held until dresp.data_ok
// DONE  | one-cycle completion; resp_valid unless the result was dropped
module dbus_req_ctrl
  import dbus_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [63:0] memAddr,
  input  logic [63:0] writeData,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [63:0] readData,
  output logic        misalign,
  dbus_req_ctrl_if.master dbus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        load_q, load_d;
  msize_t      size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;
  logic        drop_q, drop_d;
  logic [63:0] rdata_q, rdata_d;

  // addr_ok only matters for pipelined buses; this controller waits for data_ok.
  logic unused_addr_ok;
  assign unused_addr_ok = dbus.dresp.addr_ok;

  // Decode of the operation presented in IDLE.
  logic        start_req;
  logic        is_load;
  logic        mis_addr;
  logic        mis;
  msize_t      size_in;
  logic [7:0]  strb_mask;
  logic [63:0] wmask;

  always_comb begin
    mis_addr  = 1'b0;
    size_in   = MSIZE1;
    strb_mask = 8'h01;
    wmask     = 64'h0000_0000_0000_00FF;
    case (funct3[1:0])
      2'b00: begin
        mis_addr  = 1'b0;
        size_in   = MSIZE1;
        strb_mask = 8'h01;
        wmask     = 64'h0000_0000_0000_00FF;
      end
      2'b01: begin
        mis_addr  = memAddr[0];
        size_in   = MSIZE2;
        strb_mask = 8'h03;
        wmask     = 64'h0000_0000_0000_FFFF;
      end
      2'b10: begin
        mis_addr  = |memAddr[1:0];
        size_in   = MSIZE4;
        strb_mask = 8'h0F;
        wmask     = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        mis_addr  = |memAddr[2:0];
        size_in   = MSIZE8;
        strb_mask = 8'hFF;
        wmask     = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
  end

  // A load wins when both direction bits are set; an "unsigned" store is
  // illegal and is rejected like a misaligned access whatever ALIGN_CHECK says.
  assign start_req = op_valid & ~flush & (memRead | memWrite);
  assign is_load   = memRead;
  assign mis       = (~is_load & funct3[2]) | (ALIGN_CHECK & mis_addr);

  // Load result: pick the lane from the latched address, then extend.
  logic [63:0] lane;
  logic [63:0] load_ext;

  always_comb begin
    lane     = dbus.dresp.data >> {addr_q[2:0], 3'b000};
    load_ext = lane;
    case (f3_q[1:0])
      2'b00:   load_ext = f3_q[2] ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'b01:   load_ext = f3_q[2] ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'b10:   load_ext = f3_q[2] ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      f3_q     <= '0;
      load_q   <= 1'b0;
      size_q   <= MSIZE1;
      strobe_q <= '0;
      wdata_q  <= '0;
      drop_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      f3_q     <= f3_d;
      load_q   <= load_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      drop_q   <= drop_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    load_d     = load_q;
    size_d     = size_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    drop_d     = drop_q;
    rdata_d    = rdata_q;
    stall      = 1'b0;
    misalign   = 1'b0;
    resp_valid = 1'b0;
    readData   = '0;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (start_req) begin
          if (mis) begin
            misalign = 1'b1;
          end else begin
            stall    = 1'b1;
            state_d  = S_REQ;
            addr_d   = memAddr;
            f3_d     = funct3;
            load_d   = is_load;
            size_d   = size_in;
            strobe_d = is_load ? 8'h00 : (strb_mask << memAddr[2:0]);
            wdata_d  = is_load ? 64'd0 : ((writeData & wmask) << {memAddr[2:0], 3'b000});
          end
        end
      end

      S_REQ: begin
        // A flush releases the pipeline but the bus transaction still runs
        // to completion; only its result is thrown away.
        if (flush) drop_d = 1'b1;
        else       stall  = 1'b1;
        if (dbus.dresp.data_ok) begin
          rdata_d = load_q ? load_ext : 64'd0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (!drop_q && !flush) begin
          resp_valid = 1'b1;
          readData   = rdata_q;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  dbus_req_t req;

  always_comb begin
    req        = '0;
    req.valid  = (state_q == S_REQ);
    req.addr   = addr_q;
    req.size   = size_q;
    req.strobe = strobe_q;
    req.data   = wdata_q;
  end

  assign dbus.dreq = req;

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// Self-checking bench for dbus_req_ctrl: directed vector table, hand-written
// flush/reset sequences, and randomized operations against a byte-level model.
module tb_dbus_req_ctrl;
  import dbus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid, memRead, memWrite, flush;
  logic [2:0]  funct3;
  logic [63:0] memAddr, writeData;
  logic        stall, resp_valid, misalign;
  logic [63:0] readData;

  int checks = 0;
  int errors = 0;

  dbus_req_ctrl_if dbus ();

  dbus_req_ctrl #(.ALIGN_CHECK(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op_valid   (op_valid),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .memAddr    (memAddr),
    .writeData  (writeData),
    .flush      (flush),
    .stall      (stall),
    .resp_valid (resp_valid),
    .readData   (readData),
    .misalign   (misalign),
    .dbus       (dbus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  msize_t msz [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_mis(input bit ld, input logic [2:0] f3, input logic [63:0] a);
    return (!ld && f3[2]) || ((a % 64'(m_size(f3))) != 64'd0);
  endfunction

  function automatic logic [7:0] m_strb(input bit ld, input logic [2:0] f3, input logic [63:0] a);
    logic [7:0] s = 8'h00;
    if (!ld)
      for (int i = 0; i < m_size(f3); i++) s[int'(a % 8) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input bit ld, input logic [2:0] f3,
                                          input logic [63:0] a, input logic [63:0] w);
    logic [63:0] d = 64'd0;
    if (!ld)
      for (int i = 0; i < m_size(f3); i++) d[(int'(a % 8) + i) * 8 +: 8] = w[i * 8 +: 8];
    return d;
  endfunction

  function automatic logic [63:0] m_rdata(input bit ld, input logic [2:0] f3,
                                          input logic [63:0] a, input logic [63:0] bus);
    logic [63:0] v = 64'd0;
    int n;
    if (!ld) return 64'd0;
    for (int i = 0; i < m_size(f3); i++) v[i * 8 +: 8] = bus[(int'(a % 8) + i) * 8 +: 8];
    n = m_size(f3) * 8;
    if (!f3[2] && n < 64 && v[n - 1])
      for (int j = n; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  // ---------------- one complete operation with checks ----------------
  // lat = index of the REQ cycle in which data_ok is returned.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] bus, input int lat, input bit e_mis,
                       input logic [7:0] e_strb, input logic [63:0] e_data,
                       input logic [63:0] e_rd);
    op_valid = 1'b1; memRead = rd; memWrite = wr;
    funct3 = f3; memAddr = addr; writeData = wdata;
    @(negedge clk);
    chk("misalign_start", misalign, e_mis);
    chk("stall_start", stall, !e_mis);
    chk("resp_at_start", resp_valid, 1'b0);
    chk("valid_at_start", dbus.dreq.valid, 1'b0);
    tick();
    op_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    funct3 = ~f3; memAddr = ~addr; writeData = ~wdata;
    if (e_mis) begin
      @(negedge clk);
      chk("misalign_pulse_end", misalign, 1'b0);
      chk("valid_after_mis", dbus.dreq.valid, 1'b0);
      tick();
      return;
    end
    for (int k = 0; k <= lat; k++) begin
      dbus.dresp.data_ok = (k == lat);
      dbus.dresp.data    = (k == lat) ? bus : ~bus;
      dbus.dresp.addr_ok = 1'($urandom);
      @(negedge clk);
      chk("req_valid", dbus.dreq.valid, 1'b1);
      chk("req_addr", dbus.dreq.addr, addr);
      chk("req_size", dbus.dreq.size, msz[f3[1:0]]);
      chk("req_strobe", dbus.dreq.strobe, e_strb);
      chk("req_data", dbus.dreq.data, e_data);
      chk("stall_req", stall, 1'b1);
      chk("resp_in_req", resp_valid, 1'b0);
      tick();
    end
    dbus.dresp.data_ok = 1'b0;
    @(negedge clk);
    chk("resp_done", resp_valid, 1'b1);
    chk("readData", readData, e_rd);
    chk("valid_done", dbus.dreq.valid, 1'b0);
    chk("stall_done", stall, 1'b0);
    tick();
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] bus;
    int          lat;
    bit          mis;
    logic [7:0]  strb;
    logic [63:0] data;
    logic [63:0] rdv;
  } vec_t;

  vec_t tbl [12];

  initial begin
    msz[0] = MSIZE1; msz[1] = MSIZE2; msz[2] = MSIZE4; msz[3] = MSIZE8;

    //            rd wr f3      addr                    wdata                   bus                     lat mis strb   data                    readData
    tbl[0]  = '{1, 0, 3'b000, 64'h0000_0000_1000_0003, 64'h0,                  64'h0000_0000_8000_0000, 2, 0, 8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80};
    tbl[1]  = '{0, 1, 3'b001, 64'h0000_0000_0000_2006, 64'h0000_0000_0000_1234, 64'h0,                  0, 0, 8'hC0, 64'h1234_0000_0000_0000, 64'h0};
    tbl[2]  = '{1, 0, 3'b010, 64'h0000_0000_0000_3002, 64'h0,                  64'h0,                  0, 1, 8'h00, 64'h0,                  64'h0};
    tbl[3]  = '{1, 0, 3'b110, 64'h0000_0000_0000_4004, 64'h0,                  64'hFFFF_FFFF_0000_0001, 0, 0, 8'h00, 64'h0,                  64'h0000_0000_FFFF_FFFF};
    tbl[4]  = '{0, 1, 3'b100, 64'h0000_0000_0000_5000, 64'h55,                 64'h0,                  0, 1, 8'h00, 64'h0,                  64'h0};
    tbl[5]  = '{0, 1, 3'b011, 64'h0000_0000_0000_6008, 64'h0123_4567_89AB_CDEF, 64'h0,                  1, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};
    tbl[6]  = '{0, 1, 3'b000, 64'h0000_0000_0000_7007, 64'hAAAA_AAAA_AAAA_AA5A, 64'h0,                  1, 0, 8'h80, 64'h5A00_0000_0000_0000, 64'h0};
    tbl[7]  = '{1, 0, 3'b001, 64'h0000_0000_0000_8002, 64'h0,                  64'h0000_0000_8001_0000, 3, 0, 8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_8001};
    tbl[8]  = '{1, 0, 3'b100, 64'h0000_0000_0000_9005, 64'h0,                  64'h0000_F000_0000_0000, 0, 0, 8'h00, 64'h0,                  64'h0000_0000_0000_00F0};
    tbl[9]  = '{1, 1, 3'b010, 64'h0000_0000_0000_A004, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_0000_0000, 1, 0, 8'h00, 64'h0,                  64'h0000_0000_7FFF_FFFF};
    tbl[10] = '{1, 0, 3'b011, 64'h0000_0000_0000_B004, 64'h0,                  64'h0,                  0, 1, 8'h00, 64'h0,                  64'h0};
    tbl[11] = '{0, 1, 3'b010, 64'h0000_0000_0000_C004, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,                  2, 0, 8'hF0, 64'hCAFE_F00D_0000_0000, 64'h0};

    // ---- reset ----
    reset_n = 1'b0; op_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; flush = 1'b0;
    funct3 = 3'b0; memAddr = '0; writeData = '0;
    dbus.dresp = '0;
    #3;
    chk("rst_stall", stall, 1'b0);
    chk("rst_resp", resp_valid, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_readData", readData, 64'd0);
    chk("rst_valid", dbus.dreq.valid, 1'b0);
    chk("rst_addr", dbus.dreq.addr, 64'd0);
    chk("rst_size", dbus.dreq.size, MSIZE1);
    chk("rst_strobe", dbus.dreq.strobe, 8'h00);
    chk("rst_data", dbus.dreq.data, 64'd0);
    #5 reset_n = 1'b1;
    tick();

    // ---- directed table ----
    for (int i = 0; i < 12; i++)
      do_op(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].bus,
            tbl[i].lat, tbl[i].mis, tbl[i].strb, tbl[i].data, tbl[i].rdv);

    // ---- flush in IDLE: nothing starts ----
    op_valid = 1'b1; memRead = 1'b1; funct3 = 3'b011; memAddr = 64'h40; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", stall, 1'b0);
    chk("idle_flush_mis", misalign, 1'b0);
    tick();
    op_valid = 1'b0; memRead = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_valid", dbus.dreq.valid, 1'b0);
    tick();

    // ---- flush in 2nd REQ cycle, data_ok in 4th: result dropped ----
    op_valid = 1'b1; memRead = 1'b1; funct3 = 3'b011; memAddr = 64'h10;
    @(negedge clk);
    chk("flreq_start_stall", stall, 1'b1);
    tick();
    op_valid = 1'b0; memRead = 1'b0;
    for (int k = 0; k < 4; k++) begin
      flush = (k == 1);
      dbus.dresp.data_ok = (k == 3);
      dbus.dresp.data = 64'h1122_3344_5566_7788;
      @(negedge clk);
      chk("flreq_valid", dbus.dreq.valid, 1'b1);
      chk("flreq_stall", stall, (k == 1) ? 1'b0 : 1'b1);
      tick();
    end
    flush = 1'b0; dbus.dresp.data_ok = 1'b0;
    @(negedge clk);
    chk("flreq_resp", resp_valid, 1'b0);
    chk("flreq_readData", readData, 64'd0);
    chk("flreq_valid_done", dbus.dreq.valid, 1'b0);
    tick();
    @(negedge clk);
    chk("flreq_resp_after", resp_valid, 1'b0);
    tick();

    // ---- flush in DONE: pulse suppressed ----
    op_valid = 1'b1; memRead = 1'b1; funct3 = 3'b010; memAddr = 64'h20;
    tick();
    op_valid = 1'b0; memRead = 1'b0;
    dbus.dresp.data_ok = 1'b1; dbus.dresp.data = 64'h0000_0000_0000_0042;
    tick();
    dbus.dresp.data_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fldone_resp", resp_valid, 1'b0);
    chk("fldone_readData", readData, 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("fldone_resp_after", resp_valid, 1'b0);
    tick();

    // ---- reset mid-REQ: abandoned, no response afterwards ----
    op_valid = 1'b1; memRead = 1'b1; funct3 = 3'b011; memAddr = 64'h88;
    tick();
    op_valid = 1'b0; memRead = 1'b0;
    @(negedge clk);
    chk("rreq_valid_before", dbus.dreq.valid, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("rreq_valid_async", dbus.dreq.valid, 1'b0);
    chk("rreq_addr_async", dbus.dreq.addr, 64'd0);
    chk("rreq_stall_async", stall, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dbus.dresp.data_ok = (k == 0);
      @(negedge clk);
      chk("rreq_resp_after", resp_valid, 1'b0);
      chk("rreq_valid_after", dbus.dreq.valid, 1'b0);
      tick();
    end
    dbus.dresp.data_ok = 1'b0;

    // ---- randomized operations against the model ----
    for (int n = 0; n < 80; n++) begin
      int          kind;
      bit          rd, wr, ld;
      logic [2:0]  f3;
      logic [63:0] a, w, b;
      int          lat;
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      ld = rd;
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~(64'(m_size(f3)) - 64'd1);
      w  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      lat = $urandom_range(0, 3);
      do_op(rd, wr, f3, a, w, b, lat, m_mis(ld, f3, a),
            m_strb(ld, f3, a), m_wdata(ld, f3, a, w), m_rdata(ld, f3, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_req_ctrl.md
DBUS_REQ_CTRL -- requirements
Module: dbus_req_ctrl

Interface
REQ-001 Parameter: ALIGN_CHECK, 1, when 1 a misaligned access raises misalign and issues no bus request; when 0 alignment is not checked.
REQ-002 Port: clk  input  1  single clock, rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: op_valid  input  1  the memory stage holds a memory operation this cycle.
REQ-005 Port: memRead  input  1  the operation is a load.
REQ-006 Port: memWrite  input  1  the operation is a store.
REQ-007 Port: funct3  input  3  access kind: bit 2 = unsigned; bits 1:0 = b/h/w/d as 00/01/10/11.
REQ-008 Port: memAddr  input  64  virtual byte address.
REQ-009 Port: writeData  input  64  store data, right-aligned.
REQ-010 Port: flush  input  1  discard the current operation's result.
REQ-011 Port: stall  output  1  the pipeline must hold the memory stage.
REQ-012 Port: resp_valid  output  1  one-cycle pulse: the operation has completed.
REQ-013 Port: readData  output  64  extended load result; valid while resp_valid is high.
REQ-014 Port: misalign  output  1  one-cycle pulse: the access was misaligned and was not issued.
REQ-015 Port: dreq  output  dbus_req_t  data bus request (valid, addr, size, strobe, data).
REQ-016 Port: dresp  input  dbus_resp_t  data bus response (addr_ok, data_ok, data).

Function
REQ-017 States SHALL be IDLE, REQ, and DONE.
REQ-018 Start condition: in IDLE, with op_valid=1, flush=0, and memRead|memWrite=1, the block SHALL latch the address, funct3, write data, and direction, then go to REQ.
- If both memRead and memWrite are 1, the operation SHALL be a load.
REQ-019 Misalignment (ALIGN_CHECK=1): the access is misaligned when memAddr mod size != 0 (size = 1<<funct3[1:0]).
- The block SHALL NOT enter REQ.
- misalign SHALL pulse for 1 cycle.
- stall SHALL be 0.
REQ-020 A store with funct3[2]=1 SHALL be treated as misaligned (illegal); no bus request is issued.
REQ-021 In REQ:
- dreq.valid SHALL be 1.
- dreq.addr, size, strobe, and data SHALL come only from the latched copies.
- These fields SHALL stay stable until the cycle in which dresp.data_ok=1.
REQ-022 dreq.size SHALL be MSIZE1/2/4/8 for funct3[1:0] = 00/01/10/11.
REQ-023 Load requests: dreq.strobe SHALL be 8'h00.
REQ-024 Store requests:
- dreq.strobe SHALL be (2^size−1) << addr[2:0].
- dreq.data SHALL be writeData << (8·addr[2:0]); unused bytes are 0.
REQ-025 On a cycle in REQ with dresp.data_ok=1:
- The block SHALL capture dresp.data and go to DONE.
- dreq.valid SHALL be 0 from the next cycle.
- dresp.addr_ok SHALL have no effect on the state.
REQ-026 In DONE, the block SHALL pulse resp_valid=1 for exactly 1 cycle, then return to IDLE.
REQ-027 readData SHALL select the byte lane given by the latched addr[2:0] and width.
- Sign-extend when funct3[2]=0; zero-extend when funct3[2]=1.
- For a store, readData SHALL be 0.
REQ-028 stall SHALL be 1 when:
- in IDLE with an accepted start, or
- in REQ.
In DONE and in all other cases, stall SHALL be 0.
REQ-029 Minimum latency: start cycle → REQ; data_ok in the first REQ cycle → resp_valid 2 cycles after the start cycle.
REQ-030 Flush in IDLE: no operation SHALL start.
REQ-031 Flush in REQ: the bus transaction SHALL complete (valid is never dropped before data_ok).
- A "drop" flag SHALL be set.
- DONE SHALL suppress resp_valid; readData SHALL be 0.
- stall SHALL go low in the cycle flush is sampled.
REQ-032 Flush in DONE: resp_valid SHALL be suppressed in that cycle.
REQ-033 Back-to-back operations: a new operation SHALL be accepted only in IDLE, so there is 1 idle cycle (the DONE cycle) between transactions.

Reset
REQ-034 While reset_n=0, asynchronously:
- state = IDLE;
- dreq.valid = 0, dreq.addr = 0, dreq.size = MSIZE1, dreq.strobe = 0, dreq.data = 0;
- stall = 0, resp_valid = 0, misalign = 0, readData = 0;
- drop flag = 0.
REQ-035 Reset asserted in REQ SHALL abandon the transaction immediately.
- After release, the block SHALL start in IDLE with no response pulse.

Verification
REQ-036 lb at addr 0x...03, data_ok after 3 REQ cycles, dresp.data=0x0000_0000_8000_0000 → dreq fields stable for 3 cycles; resp_valid 1 cycle; readData=0xFFFF_FFFF_FFFF_FF80.
REQ-037 sh at addr 0x...06, writeData=0x1234 → strobe=8'hC0, data=0x1234_0000_0000_0000, size=MSIZE2.
REQ-038 lw at addr 0x...02 with ALIGN_CHECK=1 → misalign 1-cycle pulse, dreq.valid never 1, stall=0.
REQ-039 ld accepted, flush pulsed in the 2nd REQ cycle, data_ok in the 4th → dreq.valid stays 1 until data_ok; no resp_valid pulse.
REQ-040 lwu at addr 0x...04, data_ok in the same cycle REQ is entered, dresp.data=0xFFFF_FFFF_0000_0001 → resp_valid at start+2; readData=0x0000_0000_FFFF_FFFF.
REQ-041 reset_n driven low mid-REQ → dreq.valid=0 asynchronously; after release, with no operation presented, resp_valid stays 0.
